// File: rtl/accel_hex_formatter_pkg.sv
// Shared types and constants for the accelerometer hex line formatter.
// Holds the FSM state type, ASCII bytes, line lengths and the nibble encoder.
package accel_hex_formatter_pkg;

  typedef enum logic [0:0] {
    FMT_IDLE,
    FMT_EMIT
  } fmt_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int unsigned LINE_LEN_SEQ   = 9;
  localparam int unsigned LINE_LEN_NOSEQ = 6;

  // Uppercase hex: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/accel_hex_formatter_if.sv
// Generic AXI-Stream bundle used for both the sample input and the byte output.
// Source drives the payload and tvalid; Sink drives tready.
interface axis_interface #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KEEP_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport Source (
    output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport Sink (
    input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/accel_hex_formatter.sv
// Turns each 16-bit accelerometer sample into one ASCII line ("SS XXXX\r\n" or
// "XXXX\r\n") on an 8-bit AXI-Stream feeding a UART transmitter.
module accel_hex_formatter
  import accel_hex_formatter_pkg::*;
#(
  parameter int unsigned SEQ_ENABLE = 1
) (
  input  logic          clk,
  input  logic          reset,
  axis_interface.Sink   sample_stream,
  axis_interface.Source byte_stream,
  output logic          busy
);

  localparam int unsigned LineLen = (SEQ_ENABLE != 0) ? LINE_LEN_SEQ : LINE_LEN_NOSEQ;
  localparam logic [3:0]  LastIdx = 4'(LineLen - 1);

  fmt_state_t  r_state, w_state_d;
  logic [15:0] r_sample, w_sample_d;
  logic [7:0]  r_seq, w_seq_d;
  logic [3:0]  r_byte_idx, w_byte_idx_d;

  logic       w_in_hs;
  logic       w_out_hs;
  logic [3:0] w_pos;
  logic [7:0] w_byte;
  logic       w_unused_sideband;

  assign w_unused_sideband = ^{sample_stream.tkeep, sample_stream.tlast, sample_stream.tid,
                               sample_stream.tdest, sample_stream.tuser};

  // Reset masks tready so an upstream handshake is never half-seen during reset.
  assign sample_stream.tready = (r_state == FMT_IDLE) && !reset;
  assign busy                 = (r_state == FMT_EMIT);

  assign w_in_hs  = sample_stream.tvalid && sample_stream.tready;
  assign w_out_hs = byte_stream.tvalid && byte_stream.tready;

  always_comb begin
    w_state_d    = r_state;
    w_sample_d   = r_sample;
    w_seq_d      = r_seq;
    w_byte_idx_d = r_byte_idx;
    unique case (r_state)
      FMT_IDLE: begin
        if (w_in_hs) begin
          w_sample_d   = sample_stream.tdata;
          w_byte_idx_d = 4'd0;
          w_state_d    = FMT_EMIT;
        end
      end
      FMT_EMIT: begin
        if (w_out_hs) begin
          if (r_byte_idx == LastIdx) begin
            w_seq_d      = r_seq + 8'd1;
            w_byte_idx_d = 4'd0;
            w_state_d    = FMT_IDLE;
          end else begin
            w_byte_idx_d = r_byte_idx + 4'd1;
          end
        end
      end
      default: w_state_d = FMT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FMT_IDLE;
      r_sample   <= '0;
      r_seq      <= '0;
      r_byte_idx <= '0;
    end else begin
      r_state    <= w_state_d;
      r_sample   <= w_sample_d;
      r_seq      <= w_seq_d;
      r_byte_idx <= w_byte_idx_d;
    end
  end

  // Without the sequence prefix the line is the tail of the full 9-byte layout.
  assign w_pos = (SEQ_ENABLE != 0) ? r_byte_idx : r_byte_idx + 4'd3;

  always_comb begin
    w_byte = 8'h00;
    case (w_pos)
      4'd0:    w_byte = nibble_to_ascii(r_seq[7:4]);
      4'd1:    w_byte = nibble_to_ascii(r_seq[3:0]);
      4'd2:    w_byte = ASCII_SPACE;
      4'd3:    w_byte = nibble_to_ascii(r_sample[15:12]);
      4'd4:    w_byte = nibble_to_ascii(r_sample[11:8]);
      4'd5:    w_byte = nibble_to_ascii(r_sample[7:4]);
      4'd6:    w_byte = nibble_to_ascii(r_sample[3:0]);
      4'd7:    w_byte = ASCII_CR;
      4'd8:    w_byte = ASCII_LF;
      default: w_byte = 8'h00;
    endcase
  end

  assign byte_stream.tvalid = busy;
  assign byte_stream.tdata  = busy ? w_byte : 8'h00;
  assign byte_stream.tlast  = busy && (w_pos == 4'd8);
  assign byte_stream.tkeep  = '1;
  assign byte_stream.tid    = '0;
  assign byte_stream.tdest  = '0;
  assign byte_stream.tuser  = '0;

endmodule

// File: tb/tb_accel_hex_formatter.sv
// Directed and table-driven bench for accel_hex_formatter: one instance with the
// sequence prefix, one without, each with its own byte monitor.
module tb_accel_hex_formatter;

  typedef struct {
    logic [7:0] d;
    logic       last;
    int         cyc;
  } rx_t;

  typedef struct {
    logic [15:0] s;
    logic [71:0] line;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode1 = 0;  // 0: ready high, 1: random, 2: ready low
  logic busy1, busy0;

  rx_t  rx1[$];
  rx_t  rx0[$];
  vec_t v1[5];
  vec_t v0[2];
  int   acc[5];
  int   fst[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_interface #(.DATA_WIDTH(16)) s1_if ();
  axis_interface #(.DATA_WIDTH(8))  b1_if ();
  axis_interface #(.DATA_WIDTH(16)) s0_if ();
  axis_interface #(.DATA_WIDTH(8))  b0_if ();

  accel_hex_formatter #(.SEQ_ENABLE(1)) u_dut1 (
    .clk           (clk),
    .reset         (reset),
    .sample_stream (s1_if),
    .byte_stream   (b1_if),
    .busy          (busy1)
  );

  accel_hex_formatter #(.SEQ_ENABLE(0)) u_dut0 (
    .clk           (clk),
    .reset         (reset),
    .sample_stream (s0_if),
    .byte_stream   (b0_if),
    .busy          (busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk_line(input logic [7:0] q, input logic [15:0] s);
    string hx = "0123456789ABCDEF";
    return {hx[q[7:4]], hx[q[3:0]], 8'h20, hx[s[15:12]], hx[s[11:8]], hx[s[7:4]],
            hx[s[3:0]], 8'h0D, 8'h0A};
  endfunction

  // Byte-stream ready driver for the prefixed instance.
  always @(posedge clk) begin
    #1;
    case (rdy_mode1)
      0:       b1_if.tready = 1'b1;
      1:       b1_if.tready = 1'($urandom_range(0, 1));
      default: b1_if.tready = 1'b0;
    endcase
  end

  // Monitors: record handshakes and check AXIS hold rules between edges.
  logic [7:0] p1_d, p0_d;
  logic       p1_l, p0_l;
  bit         p1_stall = 0, p0_stall = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (p1_stall) begin
        chk("b1 hold tvalid", 32'(b1_if.tvalid), 32'd1);
        chk("b1 hold tdata", 32'(b1_if.tdata), 32'(p1_d));
        chk("b1 hold tlast", 32'(b1_if.tlast), 32'(p1_l));
      end
      if (busy1) chk("s1 tready while busy", 32'(s1_if.tready), 32'd0);
      if (b1_if.tvalid && b1_if.tready) rx1.push_back('{b1_if.tdata, b1_if.tlast, cyc});
      p1_stall = b1_if.tvalid && !b1_if.tready;
      p1_d     = b1_if.tdata;
      p1_l     = b1_if.tlast;
    end else begin
      p1_stall = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (p0_stall) begin
        chk("b0 hold tvalid", 32'(b0_if.tvalid), 32'd1);
        chk("b0 hold tdata", 32'(b0_if.tdata), 32'(p0_d));
      end
      if (busy0) chk("s0 tready while busy", 32'(s0_if.tready), 32'd0);
      if (b0_if.tvalid && b0_if.tready) rx0.push_back('{b0_if.tdata, b0_if.tlast, cyc});
      p0_stall = b0_if.tvalid && !b0_if.tready;
      p0_d     = b0_if.tdata;
      p0_l     = b0_if.tlast;
    end else begin
      p0_stall = 0;
    end
  end

  // Caller must be just after a rising edge; returns just after the accepting edge.
  task automatic send(input bit which, input logic [15:0] d, output int acc_cyc);
    int n = 0;
    if (which) begin
      s1_if.tvalid = 1'b1;
      s1_if.tdata  = d;
    end else begin
      s0_if.tvalid = 1'b1;
      s0_if.tdata  = d;
    end
    @(negedge clk);
    while (!(which ? s1_if.tready : s0_if.tready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("sample accept", 32'(which ? s1_if.tready : s0_if.tready), 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    if (which) s1_if.tvalid = 1'b0;
    else       s0_if.tvalid = 1'b0;
  endtask

  task automatic get_byte(input bit which, output rx_t r);
    int n = 0;
    r = '{8'hxx, 1'bx, -1};
    while ((which ? rx1.size() : rx0.size()) == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if ((which ? rx1.size() : rx0.size()) == 0) begin
      chk("byte arrival", 32'(which ? rx1.size() : rx0.size()), 32'd1);
    end else if (which) begin
      r = rx1.pop_front();
    end else begin
      r = rx0.pop_front();
    end
  endtask

  task automatic check_line(input bit which, input logic [71:0] exp, input int n,
                            input string name, input bit tight,
                            output int first, output logic [71:0] got);
    rx_t r;
    int  prev = 0;
    got   = '0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      get_byte(which, r);
      got = {got[63:0], r.d};
      chk($sformatf("%s byte%0d", name, i), 32'(r.d), 32'(exp[8*(n-1-i) +: 8]));
      chk($sformatf("%s tlast%0d", name, i), 32'(r.last), 32'(i == n - 1));
      if (i == 0) first = r.cyc;
      else if (tight) chk($sformatf("%s spacing%0d", name, i), 32'(r.cyc - prev), 32'd1);
      prev = r.cyc;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rx1.delete();
    rx0.delete();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  rs[20];
    logic [71:0]  got;
    int           dummy;
    int           a;

    v1[0] = '{16'h1A2F, 72'h30_30_20_31_41_32_46_0D_0A};
    v1[1] = '{16'hFFFF, 72'h30_31_20_46_46_46_46_0D_0A};
    v1[2] = '{16'h0000, 72'h30_32_20_30_30_30_30_0D_0A};
    v1[3] = '{16'hC3D4, 72'h30_33_20_43_33_44_34_0D_0A};
    v1[4] = '{16'h09BE, 72'h30_34_20_30_39_42_45_0D_0A};
    v0[0] = '{16'h0000, 72'h30_30_30_30_0D_0A};
    v0[1] = '{16'h8001, 72'h38_30_30_31_0D_0A};
    for (int i = 0; i < 20; i++) rs[i] = 16'($urandom);

    {s1_if.tvalid, s1_if.tdata, s1_if.tkeep, s1_if.tlast} = '0;
    {s1_if.tid, s1_if.tdest, s1_if.tuser} = '0;
    {s0_if.tvalid, s0_if.tdata, s0_if.tkeep, s0_if.tlast} = '0;
    {s0_if.tid, s0_if.tdest, s0_if.tuser} = '0;
    b1_if.tready = 1'b1;
    b0_if.tready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset b1 tvalid", 32'(b1_if.tvalid), 32'd0);
    chk("reset b1 tdata", 32'(b1_if.tdata), 32'd0);
    chk("reset busy1", 32'(busy1), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset s1 tready", 32'(s1_if.tready), 32'd1);
    chk("post-reset s0 tready", 32'(s0_if.tready), 32'd1);
    chk("post-reset b1 tvalid", 32'(b1_if.tvalid), 32'd0);
    chk("post-reset busy0", 32'(busy0), 32'd0);

    // Back-to-back table vectors with ready held high.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 5; i++) send(1'b1, v1[i].s, acc[i]);
      end
      begin
        for (int i = 0; i < 5; i++)
          check_line(1'b1, v1[i].line, 9, $sformatf("vec%0d", i), 1'b1, fst[i], got);
      end
    join
    chk("first-byte latency", 32'(fst[0] - acc[0]), 32'd1);
    for (int i = 1; i < 5; i++) chk($sformatf("line period%0d", i), 32'(fst[i] - fst[i-1]), 32'd10);

    // Random backpressure; sequence numbers continue from 5.
    @(posedge clk);
    #1;
    rdy_mode1 = 1;
    fork
      begin
        for (int i = 0; i < 20; i++) send(1'b1, rs[i], dummy);
      end
      begin
        logic [71:0] g;
        int          f;
        for (int i = 0; i < 20; i++)
          check_line(1'b1, mk_line(8'(5 + i), rs[i]), 9, $sformatf("rand%0d", i), 1'b0, f, g);
      end
    join
    rdy_mode1 = 0;

    // Sequence wrap across 257 lines from a fresh reset.
    @(posedge clk);
    #1;
    do_reset();
    fork
      begin
        for (int i = 0; i < 257; i++) send(1'b1, 16'(i * 37), dummy);
      end
      begin
        logic [71:0] g;
        int          f;
        for (int i = 0; i < 257; i++) begin
          check_line(1'b1, mk_line(8'(i), 16'(i * 37)), 9, $sformatf("wrap%0d", i), 1'b1, f, g);
          if (i == 255) chk("line256 prefix", 32'(g[71:48]), 32'h464620);
          if (i == 256) chk("line257 prefix", 32'(g[71:48]), 32'h303020);
        end
      end
    join

    // Reset after three bytes of a line.
    @(posedge clk);
    #1;
    do_reset();
    send(1'b1, 16'h5A5A, a);
    repeat (3) @(posedge clk);
    #2;
    reset        = 1'b1;
    rdy_mode1    = 2;
    b1_if.tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid-line reset tvalid", 32'(b1_if.tvalid), 32'd0);
    chk("mid-line reset busy", 32'(busy1), 32'd0);
    chk("partial byte count", 32'(rx1.size()), 32'd3);
    for (int i = 0; i < 3 && rx1.size() > 0; i++) begin
      rx_t r;
      r = rx1.pop_front();
      chk($sformatf("partial tlast%0d", i), 32'(r.last), 32'd0);
      chk($sformatf("partial byte%0d", i), 32'(r.d), (i == 2) ? 32'h20 : 32'h30);
    end
    rx1.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    rdy_mode1 = 0;
    send(1'b1, 16'h1234, a);
    check_line(1'b1, 72'h30_30_20_31_32_33_34_0D_0A, 9, "after reset", 1'b0, dummy, got);

    // No-prefix instance: two back-to-back 6-byte lines.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 2; i++) send(1'b0, v0[i].s, acc[i]);
      end
      begin
        for (int i = 0; i < 2; i++)
          check_line(1'b0, v0[i].line, 6, $sformatf("noseq%0d", i), 1'b1, fst[i], got);
      end
    join
    chk("noseq latency", 32'(fst[0] - acc[0]), 32'd1);
    chk("noseq period", 32'(fst[1] - fst[0]), 32'd7);
    repeat (3) @(negedge clk);
    chk("noseq no extra bytes", 32'(rx0.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_hex_formatter.md
# accel_hex_formatter

Converts 16-bit accelerometer samples from the ADXL345 driver's AXI-Stream output into ASCII text lines on an 8-bit AXI-Stream. A UART transmitter consumes that stream, so raw readings can be watched on a host terminal. Sits directly downstream of the accelerometer driver and upstream of the UART TX. Each sample becomes one line: an optional 2-digit hex sequence number, a space, 4 uppercase hex digits, then CR LF.

## Interface
Parameters:
- SEQ_ENABLE, 1: 1 = prefix each line with an 8-bit sequence number in hex plus a space (9 bytes/line); 0 = sample digits plus CR LF only (6 bytes/line).

Ports:
- clk  input  1  single clock for all logic; both stream interfaces are clocked by it.
- reset  input  1  synchronous, active-high.
- sample_stream  axis_interface.Sink  DATA_WIDTH=16, KEEP_WIDTH=1  accelerometer samples in; tkeep/tlast/tid/tdest/tuser ignored.
- byte_stream  axis_interface.Source  DATA_WIDTH=8, KEEP_WIDTH=1  ASCII bytes out to the UART TX.
- busy  output  1  high while a line is being emitted.

## Operation
- States: FMT_IDLE, FMT_EMIT.
- **FMT_IDLE**
  - sample_stream.tready = 1.
  - On sample_stream.tvalid && tready: latch tdata into sample_reg, clear byte_idx to 0, go to FMT_EMIT.
- **FMT_EMIT**
  - sample_stream.tready = 0.
  - byte_stream.tdata is selected by byte_idx.
  - SEQ_ENABLE=1 order: seq[7:4], seq[3:0], 0x20, s[15:12], s[11:8], s[7:4], s[3:0], 0x0D, 0x0A.
  - SEQ_ENABLE=0 order: s[15:12], s[11:8], s[7:4], s[3:0], 0x0D, 0x0A.
- Nibble to ASCII: 0–9 map to 0x30–0x39; A–F map to 0x41–0x46 (uppercase).
- byte_idx increments only on a byte_stream handshake (tvalid && tready).
- On the handshake of the 0x0A byte:
  - seq increments (8-bit, wraps 0xFF→0x00);
  - state returns to FMT_IDLE.
- Output sideband:
  - tlast = 1 only on the 0x0A byte;
  - tkeep = 1;
  - tid, tdest, tuser = 0.
- busy = (state == FMT_EMIT).

## Timing
- Reset values:
  - byte_stream.tvalid = 0, tdata = 0, busy = 0;
  - seq = 0, byte_idx = 0, state = FMT_IDLE;
  - sample_stream.tready = 1 once reset is deasserted.
- Latency: a sample accepted on cycle N presents its first byte with tvalid = 1 on cycle N+1.
- Throughput with byte_stream.tready held high:
  - one byte per cycle;
  - a line every 10 cycles (SEQ_ENABLE=1) or 7 cycles (SEQ_ENABLE=0), including the one idle/accept cycle.
- Backpressure rules:
  - while tvalid && !tready, tdata and tlast hold stable;
  - tvalid never drops before its handshake;
  - no byte is repeated or skipped.
- Input samples are never dropped. Upstream holds tvalid while tready = 0, which is guaranteed by the AXIS contract.
- Reset mid-line:
  - tvalid = 0 on the cycle after reset is sampled;
  - the partial line is abandoned with no tlast;
  - seq restarts at 0.
- Reset has priority over any handshake in the same cycle.

## Structure
- Package accel_hex_formatter_pkg holds:
  - the state enum fmt_state_t;
  - ASCII constants ASCII_SPACE = 8'h20, ASCII_CR = 8'h0D, ASCII_LF = 8'h0A;
  - function nibble_to_ascii(logic [3:0]) returning logic [7:0];
  - localparam line lengths LINE_LEN_SEQ = 9 and LINE_LEN_NOSEQ = 6.
- Single module with no sub-module. The byte mux is a case on byte_idx, which is 4 bits wide.

## Test plan
- SEQ_ENABLE=1, reset, byte tready high, send 0x1A2F → bytes 0x30 0x30 0x20 0x31 0x41 0x32 0x46 0x0D 0x0A on consecutive cycles. First byte appears the cycle after accept; tlast is set on 0x0A only.
- Send 0xFFFF immediately after 0x1A2F → second line is "01 FFFF\r\n". sample_stream.tready stays 0 for the whole first line, and the second sample is held, not lost.
- Random byte_stream.tready (about 50 %) over 20 samples → the scoreboard rebuilds the exact text; tdata is stable whenever tvalid && !tready.
- Send 257 samples → line 256 starts "FF ", line 257 starts "00 ".
- Assert reset after 3 bytes of a line → tvalid = 0 on the next cycle, no tlast is emitted, and the next sample's line starts "00 ".
- SEQ_ENABLE=0, send 0x0000 then 0x8001 → "0000\r\n" then "8001\r\n", 6 bytes each, with tlast on each 0x0A.
